dense_param_streamer: RTL and testbench

- Transmitter for the FlattenDense parameter-load interface. FlattenDense consumes this interface.
- Reads quantized biases and weights from two narrow single-port ROMs, one word per cycle.
- Assembles them into full-width vectors and drives dense_biases_* once, then dense_weights_* once per row.
- Sits between the parameter ROMs and FlattenDense, so the dense layer is loaded with no testbench involvement.

---
 rtl/dense_param_streamer_pkg.sv | 24 ++
 rtl/dense_param_streamer_if.sv | 28 ++
 rtl/dense_param_streamer_assembler.sv | 35 +++
 rtl/dense_param_streamer.sv | 191 +++++++++++++++++++
 tb/tb_dense_param_streamer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dense_param_streamer_pkg.sv
// Shared constants, FSM state type and vector typedefs for dense_param_streamer.
package dense_pkg;

  localparam int unsigned DEF_NUM_NEURONS = 40;
  localparam int unsigned DEF_NUM_ROWS    = 40;
  localparam int unsigned DEF_WEIGHT_RES  = 8;
  localparam int unsigned DEF_BIAS_RES    = 32;
  localparam int unsigned DEF_ADDRWIDE    = 12;

  typedef enum logic [2:0] {
    IDLE,
    FILL_B,
    DRAIN_B,
    SEND_B,
    FILL_W,
    DRAIN_W,
    SEND_W,
    DONE
  } state_e;

  typedef logic [DEF_WEIGHT_RES-1:0] weight_vec_t [0:DEF_NUM_NEURONS-1];
  typedef logic [DEF_BIAS_RES-1:0]   bias_vec_t   [0:DEF_NUM_NEURONS-1];

endpackage

// File: rtl/dense_param_streamer_if.sv
// FlattenDense parameter-load bus: bias vector once, then one weight vector per row.
interface dense_param_streamer_if
  import dense_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int unsigned WEIGHT_RES  = DEF_WEIGHT_RES,
  parameter int unsigned BIAS_RES    = DEF_BIAS_RES,
  parameter int unsigned ADDRWIDE    = DEF_ADDRWIDE
);

  logic                  dense_biases_valid_o;
  logic [BIAS_RES-1:0]   dense_biases_data_o  [0:NUM_NEURONS-1];
  logic [ADDRWIDE-1:0]   dense_biases_addr_o;
  logic                  dense_weights_valid_o;
  logic [WEIGHT_RES-1:0] dense_weights_data_o [0:NUM_NEURONS-1];
  logic [ADDRWIDE-1:0]   dense_weights_addr_o;

  modport master (
    output dense_biases_valid_o, dense_biases_data_o, dense_biases_addr_o,
    output dense_weights_valid_o, dense_weights_data_o, dense_weights_addr_o
  );

  modport slave (
    input dense_biases_valid_o, dense_biases_data_o, dense_biases_addr_o,
    input dense_weights_valid_o, dense_weights_data_o, dense_weights_addr_o
  );

endinterface

// File: rtl/dense_param_streamer_assembler.sv
// param_vec_assembler: gathers one word per capture strobe into a vector.
module param_vec_assembler #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_WORDS = 40,
  parameter int unsigned IDX_W     = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cap_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] vec_o [0:NUM_WORDS-1]
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  logic [WIDTH-1:0] work [0:NUM_WORDS-1];

  // Fill a working buffer; publish the whole vector as the final word lands,
  // so the output never shows a half-refilled vector between pulses.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      work  <= '{default: '0};
      vec_o <= '{default: '0};
    end else if (cap_i) begin
      work[idx_i] <= data_i;
      if (idx_i == LAST_IDX) begin
        for (int unsigned j = 0; j < NUM_WORDS; j++) begin
          vec_o[j] <= (j == NUM_WORDS - 1) ? data_i : work[j];
        end
      end
    end
  end

endmodule

// File: rtl/dense_param_streamer.sv
// dense_param_streamer: streams biases then weight rows from two ROMs to FlattenDense.
// Optional checksum ports/logic enabled by macro DENSE_PARAM_CHECKSUM_EN.
module dense_param_streamer
  import dense_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int unsigned NUM_ROWS    = DEF_NUM_ROWS,
  parameter int unsigned WEIGHT_RES  = DEF_WEIGHT_RES,
  parameter int unsigned BIAS_RES    = DEF_BIAS_RES,
  parameter int unsigned ADDRWIDE    = DEF_ADDRWIDE
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  bias_rom_rd_o,
  output logic [ADDRWIDE-1:0]   bias_rom_addr_o,
  input  logic [BIAS_RES-1:0]   bias_rom_data_i,
  output logic                  w_rom_rd_o,
  output logic [ADDRWIDE-1:0]   w_rom_addr_o,
  input  logic [WEIGHT_RES-1:0] w_rom_data_i,
  dense_param_streamer_if.master dense
`ifdef DENSE_PARAM_CHECKSUM_EN
  ,
  output logic [31:0]           checksum_o,
  input  logic [31:0]           expected_checksum_i,
  output logic                  checksum_err_o
`endif
);

  localparam int unsigned       IDX_W    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [ADDRWIDE-1:0] LAST_ROW = ADDRWIDE'(NUM_ROWS - 1);

  if (NUM_ROWS * NUM_NEURONS > (1 << ADDRWIDE)) begin : g_addr_overflow
    $error("dense_param_streamer: NUM_ROWS*NUM_NEURONS exceeds the ROM address space");
  end

  state_e              state, state_n;
  logic [IDX_W-1:0]    idx, idx_q;
  logic [ADDRWIDE-1:0] row, w_cnt;
  logic [ADDRWIDE-1:0] b_addr_hold, w_addr_hold, row_hold;
  logic                cap_b_q, cap_w_q;
  logic                start_ok, last_word;

  assign start_ok  = (state == IDLE) && start_i;
  assign last_word = (idx == LAST_IDX);

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state and state-decoded strobes
  always_comb begin
    state_n                     = state;
    busy_o                      = 1'b0;
    done_o                      = 1'b0;
    bias_rom_rd_o               = 1'b0;
    w_rom_rd_o                  = 1'b0;
    dense.dense_biases_valid_o  = 1'b0;
    dense.dense_weights_valid_o = 1'b0;
    unique case (state)
      IDLE:    if (start_i) state_n = FILL_B;
      FILL_B: begin
        busy_o        = 1'b1;
        bias_rom_rd_o = 1'b1;
        if (last_word) state_n = DRAIN_B;
      end
      DRAIN_B: begin
        busy_o  = 1'b1;
        state_n = SEND_B;
      end
      SEND_B: begin
        busy_o                     = 1'b1;
        dense.dense_biases_valid_o = 1'b1;
        state_n                    = FILL_W;
      end
      FILL_W: begin
        busy_o     = 1'b1;
        w_rom_rd_o = 1'b1;
        if (last_word) state_n = DRAIN_W;
      end
      DRAIN_W: begin
        busy_o  = 1'b1;
        state_n = SEND_W;
      end
      SEND_W: begin
        busy_o                      = 1'b1;
        dense.dense_weights_valid_o = 1'b1;
        state_n                     = (row == LAST_ROW) ? DONE : FILL_W;
      end
      DONE: begin
        done_o  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Word/row counters, running weight address and held address values
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx         <= '0;
      idx_q       <= '0;
      row         <= '0;
      w_cnt       <= '0;
      b_addr_hold <= '0;
      w_addr_hold <= '0;
      row_hold    <= '0;
      cap_b_q     <= 1'b0;
      cap_w_q     <= 1'b0;
    end else begin
      cap_b_q <= bias_rom_rd_o;
      cap_w_q <= w_rom_rd_o;
      idx_q   <= idx;
      if (start_ok) begin
        row   <= '0;
        w_cnt <= '0;
      end
      if (bias_rom_rd_o || w_rom_rd_o) idx <= last_word ? '0 : idx + IDX_W'(1);
      if (bias_rom_rd_o) b_addr_hold <= ADDRWIDE'(idx);
      if (w_rom_rd_o) begin
        w_addr_hold <= w_cnt;
        w_cnt       <= w_cnt + ADDRWIDE'(1);
      end
      if (dense.dense_weights_valid_o) begin
        row_hold <= row;
        row      <= row + ADDRWIDE'(1);
      end
    end
  end

  // Live value while active, otherwise the last value driven
  assign bias_rom_addr_o            = bias_rom_rd_o ? ADDRWIDE'(idx) : b_addr_hold;
  assign w_rom_addr_o               = w_rom_rd_o ? w_cnt : w_addr_hold;
  assign dense.dense_weights_addr_o = dense.dense_weights_valid_o ? row : row_hold;
  assign dense.dense_biases_addr_o  = '0;

  param_vec_assembler #(
    .WIDTH    (BIAS_RES),
    .NUM_WORDS(NUM_NEURONS),
    .IDX_W    (IDX_W)
  ) u_bias_vec (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .cap_i (cap_b_q),
    .idx_i (idx_q),
    .data_i(bias_rom_data_i),
    .vec_o (dense.dense_biases_data_o)
  );

  param_vec_assembler #(
    .WIDTH    (WEIGHT_RES),
    .NUM_WORDS(NUM_NEURONS),
    .IDX_W    (IDX_W)
  ) u_weight_vec (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .cap_i (cap_w_q),
    .idx_i (idx_q),
    .data_i(w_rom_data_i),
    .vec_o (dense.dense_weights_data_o)
  );

`ifdef DENSE_PARAM_CHECKSUM_EN
  logic [31:0] sum;
  logic        err;

  // Sum every captured word; compare against the expected value on the way into DONE
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sum <= '0;
      err <= 1'b0;
    end else if (start_ok) begin
      sum <= '0;
      err <= 1'b0;
    end else begin
      if (cap_b_q) sum <= sum + 32'(bias_rom_data_i);
      if (cap_w_q) sum <= sum + 32'(w_rom_data_i);
      if (state == SEND_W && state_n == DONE) err <= (sum != expected_checksum_i);
    end
  end

  assign checksum_o     = sum;
  assign checksum_err_o = err;
`endif

endmodule

// File: tb/tb_dense_param_streamer.sv
// Directed table-driven bench for dense_param_streamer with a behavioural ROM pair.
module tb_dense_param_streamer;
  import dense_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, b_rd, w_rd;
  logic [11:0] b_addr, w_addr;
  logic [31:0] b_data;
  logic [7:0]  w_data;
`ifdef DENSE_PARAM_CHECKSUM_EN
  logic [31:0] csum, exp_csum;
  logic        csum_err;
`endif

  always #5 clk = ~clk;

  dense_param_streamer_if bus ();

  dense_param_streamer dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .busy_o         (busy),
    .done_o         (done),
    .bias_rom_rd_o  (b_rd),
    .bias_rom_addr_o(b_addr),
    .bias_rom_data_i(b_data),
    .w_rom_rd_o     (w_rd),
    .w_rom_addr_o   (w_addr),
    .w_rom_data_i   (w_data),
    .dense          (bus)
`ifdef DENSE_PARAM_CHECKSUM_EN
    ,
    .checksum_o         (csum),
    .expected_checksum_i(exp_csum),
    .checksum_err_o     (csum_err)
`endif
  );

  // ROM model: bias[i] = i*1000, weight[a] = a[7:0], one cycle read latency
  always @(posedge clk) begin
    if (b_rd) b_data <= 32'(b_addr) * 32'd1000;
    if (w_rd) w_data <= w_addr[7:0];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ROM address contiguity and strobe/valid exclusivity monitor
  bit mon_en = 1'b0;
  int exp_w  = 0;
  int exp_b  = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (w_rd) begin
        check("w_rom_addr_seq", longint'(w_addr), longint'(exp_w));
        exp_w++;
      end
      if (b_rd) begin
        check("bias_rom_addr_seq", longint'(b_addr), longint'(exp_b));
        exp_b++;
      end
      if (bus.dense_biases_valid_o || bus.dense_weights_valid_o)
        check("rd_low_in_send", longint'(b_rd | w_rd), 0);
    end
  end

  typedef enum int {
    K_BUSY, K_DONE, K_BRD, K_BADDR, K_WRD, K_WADDR,
    K_BVALID, K_BDATA, K_BDADDR, K_WVALID, K_WDATA, K_WDADDR
  } kind_e;

  typedef struct {
    int     cyc;
    kind_e  kind;
    int     idx;
    longint exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int cyc, input kind_e k, input int idx, input longint e);
    vec_t v;
    v.cyc  = cyc;
    v.kind = k;
    v.idx  = idx;
    v.exp  = e;
    tbl.push_back(v);
  endfunction

  function automatic string kname(input kind_e k);
    case (k)
      K_BUSY:   return "busy";
      K_DONE:   return "done";
      K_BRD:    return "bias_rom_rd";
      K_BADDR:  return "bias_rom_addr";
      K_WRD:    return "w_rom_rd";
      K_WADDR:  return "w_rom_addr";
      K_BVALID: return "biases_valid";
      K_BDATA:  return "biases_data";
      K_BDADDR: return "biases_addr";
      K_WVALID: return "weights_valid";
      K_WDATA:  return "weights_data";
      default:  return "weights_addr";
    endcase
  endfunction

  function automatic longint probe(input kind_e k, input int idx);
    logic [5:0] i;
    i = 6'(idx);
    case (k)
      K_BUSY:   return longint'(busy);
      K_DONE:   return longint'(done);
      K_BRD:    return longint'(b_rd);
      K_BADDR:  return longint'(b_addr);
      K_WRD:    return longint'(w_rd);
      K_WADDR:  return longint'(w_addr);
      K_BVALID: return longint'(bus.dense_biases_valid_o);
      K_BDATA:  return longint'(bus.dense_biases_data_o[i]);
      K_BDADDR: return longint'(bus.dense_biases_addr_o);
      K_WVALID: return longint'(bus.dense_weights_valid_o);
      K_WDATA:  return longint'(bus.dense_weights_data_o[i]);
      default:  return longint'(bus.dense_weights_addr_o);
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    kind_e ks[12] = '{K_BUSY, K_DONE, K_BRD, K_BADDR, K_WRD, K_WADDR,
                      K_BVALID, K_BDATA, K_BDADDR, K_WVALID, K_WDATA, K_WDADDR};
    foreach (ks[j]) check({tag, "_", kname(ks[j])}, probe(ks[j], 39), 0);
    check({tag, "_biases_data0"}, probe(K_BDATA, 0), 0);
    check({tag, "_weights_data0"}, probe(K_WDATA, 0), 0);
  endtask

  int done_cnt;

  // Start a load at edge E0 and walk cycles 1..last_cyc (cycle n = n-th negedge after E0)
  task automatic run_load(input bit hold_start, input int last_cyc);
    exp_w    = 0;
    exp_b    = 0;
    done_cnt = 0;
    mon_en   = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= last_cyc; n++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      foreach (tbl[j])
        if (tbl[j].cyc == n) check(kname(tbl[j].kind), probe(tbl[j].kind, tbl[j].idx), tbl[j].exp);
      done_cnt += int'(done);
    end
  endtask

  task automatic check_full_counts(input string tag);
    check({tag, "_w_addr_count"}, longint'(exp_w), 1600);
    check({tag, "_b_addr_count"}, longint'(exp_b), 40);
    check({tag, "_done_pulses"}, longint'(done_cnt), 1);
  endtask

  initial begin
    // Expected events, relative to the start-sampling edge E0
    add(1, K_BUSY, 0, 1);      add(1, K_BRD, 0, 1);        add(1, K_BADDR, 0, 0);
    add(40, K_BRD, 0, 1);      add(40, K_BADDR, 0, 39);
    add(41, K_BRD, 0, 0);      add(41, K_BVALID, 0, 0);    add(41, K_BADDR, 0, 39);
    add(42, K_BVALID, 0, 1);   add(42, K_BDADDR, 0, 0);    add(42, K_BDATA, 0, 0);
    add(42, K_BDATA, 17, 17000); add(42, K_BDATA, 39, 39000); add(42, K_WRD, 0, 0);
    add(43, K_BVALID, 0, 0);   add(43, K_WRD, 0, 1);       add(43, K_WADDR, 0, 0);
    add(43, K_BDATA, 39, 39000);
    add(210, K_WVALID, 0, 1);  add(210, K_WDADDR, 0, 3);   add(210, K_WDATA, 5, 125);
    add(210, K_WDATA, 0, 120); add(210, K_WRD, 0, 0);
    add(211, K_WVALID, 0, 0);  add(211, K_WDADDR, 0, 3);   add(211, K_WDATA, 5, 125);
    add(211, K_WRD, 0, 1);     add(211, K_WADDR, 0, 160);
    add(252, K_WVALID, 0, 1);  add(252, K_WDADDR, 0, 4);   add(252, K_WDATA, 5, 165);
    add(336, K_WVALID, 0, 1);  add(336, K_WDADDR, 0, 6);   add(336, K_WDATA, 39, 23);
    add(1720, K_WADDR, 0, 1599); add(1721, K_WRD, 0, 0);
    add(1722, K_WVALID, 0, 1); add(1722, K_WDADDR, 0, 39); add(1722, K_WDATA, 39, 63);
    add(1722, K_WDATA, 0, 24); add(1722, K_BUSY, 0, 1);    add(1722, K_DONE, 0, 0);
    add(1723, K_DONE, 0, 1);   add(1723, K_BUSY, 0, 0);    add(1723, K_WVALID, 0, 0);
    add(1723, K_WADDR, 0, 1599); add(1723, K_WDADDR, 0, 39);
    add(1724, K_DONE, 0, 0);   add(1724, K_BUSY, 0, 0);    add(1724, K_BDATA, 39, 39000);

`ifdef DENSE_PARAM_CHECKSUM_EN
    exp_csum = '0;
`endif
    // Reset state
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Full load with a single start pulse
    run_load(1'b0, 1724);
    check_full_counts("load1");

    // Reset during row 10 FILL_W aborts without a done pulse
    exp_w  = 0;
    exp_b  = 0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 470; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort_w_rd_before", longint'(w_rd), 1);
    check("abort_w_addr_before", longint'(w_addr), 407);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("abort");
    done_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      done_cnt += int'(done) + int'(busy);
    end
    check("abort_idle_no_done", longint'(done_cnt), 0);

    // Fresh start reproduces the whole sequence from row 0
    run_load(1'b0, 1724);
    check_full_counts("load2");

    // start held high: one load, next accepted in the IDLE cycle after DONE
    run_load(1'b1, 1724);
    check_full_counts("held");
    mon_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("held_restart_busy", longint'(busy), 1);
    check("held_restart_b_rd", longint'(b_rd), 1);
    check("held_restart_b_addr", longint'(b_addr), 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef DENSE_PARAM_CHECKSUM_EN
    begin
      longint s = 0;
      for (int i = 0; i < 40; i++) s += i * 1000;
      for (int a = 0; a < 1600; a++) s += a % 256;
      exp_csum = 32'(s);
      run_load(1'b0, 1722);
      @(negedge clk);
      check("csum_done", longint'(done), 1);
      check("csum_value", longint'(csum), s);
      check("csum_err_match", longint'(csum_err), 0);
      exp_csum = 32'(s + 1);
      run_load(1'b0, 1722);
      @(negedge clk);
      check("csum_err_mismatch", longint'(csum_err), 1);
      @(negedge clk);
      check("csum_err_hold", longint'(csum_err), 1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
